// File: rtl/hough_pkg.sv
// Shared types and elaboration-time helpers for the Hough line highlighter.
package hough_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, STEP, DONE} state_t;

    // Bhaskara sine in Q(frac); exact at 0, 90, 180 and 270 degrees.
    function automatic int sin_q(int d, int frac);
        int x;
        int s;
        longint num;
        int den;
        x = d % 360;
        s = 1;
        if (x >= 180) begin
            x = x - 180;
            s = -1;
        end
        num = longint'(4 * x * (180 - x)) << frac;
        den = 40500 - x * (180 - x);
        return s * int'(num / den);
    endfunction

    function automatic int addr_bits(int w, int h);
        return $clog2(w * h);
    endfunction

    function automatic int acc_bits(int rb, int dw, int hl);
        return rb + dw + $clog2(hl) + 1;
    endfunction

endpackage

// File: rtl/line_req_fifo.sv
// Synchronous (angle, rho) request FIFO with show-ahead read data.
module line_req_fifo #(
    parameter int DEPTH = 8,
    parameter int AB    = 8,
    parameter int RB    = 12
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  logic [AB-1:0]        push_angle,
    input  logic signed [RB-1:0] push_rho,
    input  logic                 pop,
    output logic [AB-1:0]        pop_angle,
    output logic signed [RB-1:0] pop_rho,
    output logic                 full,
    output logic                 empty
);

    localparam int PB = $clog2(DEPTH);

    logic [AB-1:0]        angles [DEPTH];
    logic signed [RB-1:0] rhos   [DEPTH];
    logic [PB:0]          wp;
    logic [PB:0]          rp;

    assign empty     = (wp == rp);
    assign full      = (wp[PB] != rp[PB]) && (wp[PB-1:0] == rp[PB-1:0]);
    assign pop_angle = angles[rp[PB-1:0]];
    assign pop_rho   = rhos[rp[PB-1:0]];

    always_ff @(posedge clock) begin
        if (push && !full) begin
            angles[wp[PB-1:0]] <= push_angle;
            rhos[wp[PB-1:0]]   <= push_rho;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end

endmodule

// File: rtl/lookup_table.sv
// Sine/cosine ROM indexed by angle bin; out-of-range bins read as zero.
module lookup_table
    import hough_pkg::*;
#(
    parameter int ANGLE_RANGE = 180,
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 13,
    parameter int AB          = $clog2(ANGLE_RANGE)
) (
    input  logic [AB-1:0]                angle,
    output logic signed [DATA_WIDTH-1:0] sin_val,
    output logic signed [DATA_WIDTH-1:0] cos_val
);

    logic signed [DATA_WIDTH-1:0] sin_rom [ANGLE_RANGE];
    logic signed [DATA_WIDTH-1:0] cos_rom [ANGLE_RANGE];

    for (genvar i = 0; i < ANGLE_RANGE; i++) begin : g_rom
        localparam logic signed [DATA_WIDTH-1:0] S = DATA_WIDTH'(sin_q(i, FRAC_BITS));
        localparam logic signed [DATA_WIDTH-1:0] C = DATA_WIDTH'(sin_q(i + 90, FRAC_BITS));
        assign sin_rom[i] = S;
        assign cos_rom[i] = C;
    end

    always_comb begin
        sin_val = '0;
        cos_val = '0;
        if (int'(angle) < ANGLE_RANGE) begin
            sin_val = sin_rom[angle];
            cos_val = cos_rom[angle];
        end
    end

endmodule

// File: rtl/hough_line_highlighter.sv
// Draws queued Hough lines as clipped, de-duplicated pixel writes
// to the frame-buffer writer with full backpressure.
module hough_line_highlighter
    import hough_pkg::*;
#(
    parameter int          WIDTH          = 1280,
    parameter int          HEIGHT         = 720,
    parameter int          ANGLE_RANGE    = 180,
    parameter int          DATA_WIDTH     = 16,
    parameter int          FRAC_BITS      = 13,
    parameter int          RHO_BITS       = 12,
    parameter int          LINE_HALF_LEN  = 1024,
    parameter int          REQ_FIFO_DEPTH = 8,
    parameter logic [23:0] COLOR          = 24'h00FF00
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [$clog2(ANGLE_RANGE)-1:0]          in_angle,
    input  logic signed [RHO_BITS-1:0]              in_rho,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [addr_bits(WIDTH, HEIGHT)-1:0]     out_addr,
    output logic [23:0]                             out_din,
    output logic                                    busy,
    output logic                                    line_done,
    output logic                                    angle_err,
    output logic [15:0]                             lines_drawn
);

    localparam int AB = $clog2(ANGLE_RANGE);
    localparam int AD = addr_bits(WIDTH, HEIGHT);
    localparam int AW = acc_bits(RHO_BITS, DATA_WIDTH, LINE_HALF_LEN);
    localparam int LB = $clog2(LINE_HALF_LEN);
    localparam int CB = LB + 1;
    localparam logic signed [AW-1:0] W_S = AW'(WIDTH);
    localparam logic signed [AW-1:0] H_S = AW'(HEIGHT);

    state_t                       state;
    logic                         f_empty;
    logic                         f_full;
    logic                         pop;
    logic [AB-1:0]                f_angle;
    logic signed [RHO_BITS-1:0]   f_rho;
    logic [AB-1:0]                req_angle;
    logic signed [RHO_BITS-1:0]   req_rho;
    logic signed [DATA_WIDTH-1:0] sin_v;
    logic signed [DATA_WIDTH-1:0] cos_v;
    logic signed [AW-1:0]         rho_e, sin_e, cos_e;
    logic signed [AW-1:0]         x0, y0;
    logic signed [AW-1:0]         x_fx, y_fx;
    logic signed [AW-1:0]         px, py;
    logic [CB-1:0]                cnt;
    logic                         fin;
    logic                         have_last;
    logic [AD-1:0]                last_addr;
    logic [AD-1:0]                cand;
    logic                         in_frame;
    logic                         emit;
    logic                         stall;

    assign in_ready = !f_full;
    assign pop      = (state == IDLE) && !f_empty;
    assign busy     = !f_empty || (state != IDLE);
    assign out_din  = COLOR;

    line_req_fifo #(
        .DEPTH(REQ_FIFO_DEPTH),
        .AB   (AB),
        .RB   (RHO_BITS)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (in_valid && in_ready),
        .push_angle(in_angle),
        .push_rho  (in_rho),
        .pop       (pop),
        .pop_angle (f_angle),
        .pop_rho   (f_rho),
        .full      (f_full),
        .empty     (f_empty)
    );

    lookup_table #(
        .ANGLE_RANGE(ANGLE_RANGE),
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .AB         (AB)
    ) u_lut (
        .angle  (req_angle),
        .sin_val(sin_v),
        .cos_val(cos_v)
    );

    assign rho_e = AW'(req_rho);
    assign sin_e = AW'(sin_v);
    assign cos_e = AW'(cos_v);

    // Seed point at t = -LINE_HALF_LEN.
    assign x0 = rho_e * cos_e + (sin_e <<< LB);
    assign y0 = rho_e * sin_e - (cos_e <<< LB);

    assign px       = x_fx >>> FRAC_BITS;
    assign py       = y_fx >>> FRAC_BITS;
    assign in_frame = !px[AW-1] && !py[AW-1] && (px < W_S) && (py < H_S);
    assign cand     = AD'(py * W_S + px);
    assign emit     = in_frame && (!have_last || cand != last_addr);
    assign stall    = out_valid && !out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_addr    <= '0;
            line_done   <= 1'b0;
            angle_err   <= 1'b0;
            lines_drawn <= '0;
            req_angle   <= '0;
            req_rho     <= '0;
            x_fx        <= '0;
            y_fx        <= '0;
            cnt         <= '0;
            fin         <= 1'b0;
            have_last   <= 1'b0;
            last_addr   <= '0;
        end else begin
            line_done <= 1'b0;
            angle_err <= 1'b0;
            if (out_valid && out_ready) out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!f_empty) begin
                        req_angle <= f_angle;
                        req_rho   <= f_rho;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (int'(req_angle) >= ANGLE_RANGE) begin
                        angle_err <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        x_fx      <= x0;
                        y_fx      <= y0;
                        cnt       <= '0;
                        fin       <= 1'b0;
                        have_last <= 1'b0;
                        state     <= STEP;
                    end
                end
                STEP: begin
                    // fin: last candidate emitted, wait for it to drain.
                    if (fin) begin
                        if (out_ready) state <= DONE;
                    end else if (!stall) begin
                        if (emit) begin
                            out_valid <= 1'b1;
                            out_addr  <= cand;
                            last_addr <= cand;
                            have_last <= 1'b1;
                        end
                        x_fx <= x_fx - sin_e;
                        y_fx <= y_fx + cos_e;
                        cnt  <= cnt + 1'b1;
                        if (&cnt) begin
                            if (emit) fin <= 1'b1;
                            else state <= DONE;
                        end
                    end
                end
                DONE: begin
                    line_done   <= 1'b1;
                    lines_drawn <= lines_drawn + 16'd1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/hough_line_highlighter.md
Name: hough_line_highlighter

Overview:
Parametrised successor of the single-line highlighter in the Hough transform back end. It accepts a stream of (angle, rho) line requests from the peak detector into an internal request FIFO. Each line is drawn symmetrically about its foot point, clipped to the frame, with duplicate pixels suppressed. Pixel writes go to the frame-buffer writer over a valid/ready handshake with full backpressure.

Parameters:
WIDTH, 1280, frame width in pixels
HEIGHT, 720, frame height in pixels
ANGLE_RANGE, 180, number of angle bins (1 degree each)
DATA_WIDTH, 16, signed sine/cosine word width
FRAC_BITS, 13, fractional bits of sine/cosine (1.0 = 8192)
RHO_BITS, 12, signed rho width
LINE_HALF_LEN, 1024, steps drawn each side of the foot point; power of two
REQ_FIFO_DEPTH, 8, line request FIFO depth; power of two
COLOR, 24'h00FF00, RGB value written for every pixel

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  line request valid
in_ready  out  1  request FIFO not full
in_angle  in  $clog2(ANGLE_RANGE)  angle bin
in_rho  in  RHO_BITS  signed rho
out_valid  out  1  pixel write valid
out_ready  in  1  frame-buffer writer accepts
out_addr  out  $clog2(WIDTH*HEIGHT)  pixel address, y*WIDTH+x
out_din  out  24  pixel colour (always COLOR)
busy  out  1  FIFO non-empty or FSM not IDLE
line_done  out  1  one-cycle pulse when a line finishes
angle_err  out  1  one-cycle pulse when a request is discarded for angle >= ANGLE_RANGE
lines_drawn  out  16  count of completed lines; wraps at 2^16

Behaviour:
- Reset (sync, active-high): FIFO flushed; state IDLE; out_valid=0, out_addr=0, out_din=COLOR, line_done=0, angle_err=0, lines_drawn=0, busy=0. in_ready=1 in the first cycle after reset. Reset mid-line abandons the line with no line_done and no further writes.
- Request push: when in_valid && in_ready. in_ready = !fifo_full. A push and a pop in the same cycle while full is not allowed, because in_ready is already 0.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop and go to SETUP.
  - SETUP (1 cycle):
    - If angle >= ANGLE_RANGE: pulse angle_err and return to IDLE. No line_done; lines_drawn unchanged.
    - Otherwise register the products rho*cos and rho*sin in Q(FRAC_BITS), seeded at t = -LINE_HALF_LEN.
    - Go to STEP.
  - STEP: one candidate point per cycle while not stalled. Fixed-point point: x_fx(t) = rho*cos - t*sin, y_fx(t) = rho*sin + t*cos. It is accumulated incrementally (x_fx -= sin, y_fx += cos), which is exact.
    - Pixel coordinate: arithmetic shift right by FRAC_BITS (floor).
    - Emit only if 0<=x<WIDTH, 0<=y<HEIGHT, and the address differs from the last emitted address of the same line.
    - t runs -LINE_HALF_LEN to LINE_HALF_LEN-1 (2*LINE_HALF_LEN candidates).
    - After the last candidate is resolved, go to DONE.
  - DONE (1 cycle): pulse line_done, increment lines_drawn, go to IDLE.
- Accumulator width is sized so the full t range cannot overflow: RHO_BITS + DATA_WIDTH + $clog2(LINE_HALF_LEN) + 1 bits.
- Output handshake: out_addr and out_valid are registered.
  - While out_valid && !out_ready, out_addr is held stable and STEP stalls (t does not advance).
  - A transfer occurs on out_valid && out_ready. A new pixel may load in the same cycle.
  - DONE is entered only after the last pixel has transferred.
- Latency: first candidate resolves 2 cycles after the pop. Unstalled, one line takes 2*LINE_HALF_LEN + 3 cycles.
- Lookup table: exact at 0 and 90 degrees (cos(0)=8192, sin(0)=0, sin(90)=8192, cos(90)=0).
- busy drops in the cycle after DONE if the FIFO is empty.

Decomposition:
- Package hough_pkg holds:
  - FSM enum (IDLE, SETUP, STEP, DONE)
  - the sine/cosine ROM constant function
  - address-width and accumulator-width helper functions
- Sub-modules:
  - lookup_table (shared with the accumulator stage) for sine and cosine.
  - One new sub-module, line_req_fifo: synchronous FIFO, REQ_FIFO_DEPTH x (angle, rho), with full/empty flags.

Test Plan:
1. WIDTH=16, HEIGHT=12, LINE_HALF_LEN=4, out_ready=1; request angle 0, rho 5 -> writes to 5, 21, 37, 53 in order; then one line_done pulse and lines_drawn=1.
2. Same configuration; request angle 90, rho 5 -> writes to 84, 83, 82, 81, 80; t>0 points (x<0) are clipped, no writes.
3. Repeat scenario 1 with out_ready toggling 1-0-0-1 -> same 4 addresses in the same order; out_addr stable during every stall; no drops or duplicates.
4. Push 9 requests with the FSM stalled (out_ready=0, REQ_FIFO_DEPTH=8) -> in_ready=0 after the 8th accepted request; the 9th is held off; all 8 lines complete once out_ready=1, giving lines_drawn=8.
5. Request angle 200 (ANGLE_RANGE=180) followed by a valid request -> one angle_err pulse, no writes for the bad request; the valid line draws normally; lines_drawn=1.
6. Assert reset for 1 cycle mid-STEP after 2 pixels -> next cycle out_valid=0, busy=0, in_ready=1, lines_drawn=0; no line_done; a new request then draws correctly.
